updown_counter_mod: RTL and testbench
=====================================

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits; legal range is 2 to 32.
REQ-002 Parameter RESET_VAL, default 0, SHALL set the count value loaded on reset; it SHALL be less than 2^WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port en, input, 1 bit: count enable.
REQ-006 Port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 Port load, input, 1 bit: synchronous load strobe.
REQ-008 Port load_val, input, WIDTH bits: value to load.
REQ-009 Port limit, input, WIDTH bits: inclusive upper bound of the count range [0, limit].
REQ-010 Port sat_mode, input, 1 bit: 1 means saturate at the bounds; 0 means wrap at the bounds.
REQ-011 Port count, output, WIDTH bits: registered counter value.
REQ-012 Port at_max, output, 1 bit: combinational; high when count == limit.
REQ-013 Port at_zero, output, 1 bit: combinational; high when count == 0.
REQ-014 Port wrap, output, 1 bit: registered; one-cycle pulse marking a wrap event.
REQ-015 Port sat_hit, output, 1 bit: registered; one-cycle pulse marking a blocked step.

Function
REQ-016 Each rising clk edge SHALL apply exactly one action, in this priority order:
- load
- enabled step
- hold
REQ-017 A load (load=1) SHALL set count to min(load_val, limit) regardless of en, up and sat_mode.
- A load SHALL clear wrap and sat_hit for the next cycle.
REQ-018 A hold (load=0, en=0) SHALL keep count unchanged and drive wrap=0 and sat_hit=0 the next cycle.
REQ-019 An up step (load=0, en=1, up=1) with count < limit SHALL set count to count+1.
REQ-020 An up step with count >= limit SHALL behave by mode:
- sat_mode=0: count becomes 0 and wrap pulses.
- sat_mode=1: count becomes limit and sat_hit pulses.
REQ-021 A down step (load=0, en=1, up=0) with 0 < count <= limit SHALL set count to count-1.
REQ-022 A down step with count == 0 SHALL behave by mode:
- sat_mode=0: count becomes limit and wrap pulses.
- sat_mode=1: count stays 0 and sat_hit pulses.
REQ-023 A down step with count > limit (limit lowered at run time) SHALL set count to limit with no wrap and no sat_hit.
REQ-024 wrap and sat_hit SHALL be high only in the single cycle following the edge that caused the event.
- They SHALL never be high in the same cycle.
REQ-025 With limit == 0, every enabled step SHALL leave count at 0.
- wrap SHALL pulse when sat_mode=0; sat_hit SHALL pulse when sat_mode=1.
REQ-026 limit == 2^WIDTH-1 SHALL give full-range modulo-2^WIDTH counting.
- No intermediate arithmetic overflow SHALL be visible on count.
REQ-027 Direction, mode and limit changes SHALL take effect on the very next edge, with no pipeline delay.

Reset
REQ-028 Asserting reset SHALL immediately, independent of clk, drive count=RESET_VAL, wrap=0 and sat_hit=0.
REQ-029 While reset is high, load and en SHALL be ignored.
- The first action after deassertion SHALL occur on the first rising clk edge at which reset is low.
REQ-030 Reset asserted mid-pulse SHALL clear wrap and sat_hit at once.
- at_max and at_zero SHALL track count == RESET_VAL.

Verification (WIDTH=4, RESET_VAL=0)
REQ-031 Up wrap:
- Stimulus: limit=9, sat_mode=0, en=1, up=1 after reset; run 12 cycles.
- Response: count goes 1..9, 0, 1, 2; wrap is high exactly one cycle, when count first reads 0; at_max is high while count=9.
REQ-032 Down saturation:
- Stimulus: load 2 with limit=15, then sat_mode=1, en=1, up=0 for 4 cycles.
- Response: count goes 1, 0, 0, 0; sat_hit is high on the two cycles showing the held 0; wrap stays 0.
REQ-033 Down wrap plus load clamp:
- Stimulus: limit=5, sat_mode=0, down from 0.
- Response: count=5 with a wrap pulse.
- Stimulus: load_val=12 with limit=5.
- Response: count=5.
REQ-034 Run-time limit drop:
- Stimulus: count=12, limit changed to 7, one down step.
- Response: count=7, no pulse.
- Stimulus: one further up step with sat_mode=0.
- Response: count=0 with a wrap pulse.
REQ-035 Priority and async reset:
- Stimulus: load=1, en=1, up=1, load_val=3.
- Response: count=3.
- Stimulus: reset asserted between clock edges while count=6.
- Response: count=0 before the next edge; counting resumes from 0 on the first edge after release.
REQ-036 Full range:
- Stimulus: limit=15, sat_mode=0, 17 up steps from 0.
- Response: count reaches 15, then 0, then 1; wrap pulses once.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Up/down counter over the range [0, limit] with selectable wrap or saturate
// behaviour at the bounds, synchronous load and registered event pulses.
module updown_counter_mod #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_RESET = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             sat_hit_r;

  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             sat_hit_nxt_s;

  // Next-state selection: load beats an enabled step, which beats hold.
  // Increments only happen below limit and decrements only above zero, so
  // the arithmetic never overflows even when limit spans the full width.
  always_comb begin
    count_nxt_s   = count_r;
    wrap_nxt_s    = 1'b0;
    sat_hit_nxt_s = 1'b0;
    if (load) begin
      if (load_val > limit) begin
        count_nxt_s = limit;
      end else begin
        count_nxt_s = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (count_r < limit) begin
          count_nxt_s = count_r + CNT_ONE;
        end else if (sat_mode) begin
          count_nxt_s   = limit;
          sat_hit_nxt_s = 1'b1;
        end else begin
          count_nxt_s = CNT_ZERO;
          wrap_nxt_s  = 1'b1;
        end
      end else begin
        // A count stranded above a lowered limit snaps back silently.
        if (count_r > limit) begin
          count_nxt_s = limit;
        end else if (count_r != CNT_ZERO) begin
          count_nxt_s = count_r - CNT_ONE;
        end else if (sat_mode) begin
          count_nxt_s   = CNT_ZERO;
          sat_hit_nxt_s = 1'b1;
        end else begin
          count_nxt_s = limit;
          wrap_nxt_s  = 1'b1;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and pulse registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= CNT_RESET;
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      wrap_r    <= wrap_nxt_s;
      sat_hit_r <= sat_hit_nxt_s;
    end
  end

  assign count   = count_r;
  assign wrap    = wrap_r;
  assign sat_hit = sat_hit_r;
  assign at_max  = (count_r == limit);
  assign at_zero = (count_r == CNT_ZERO);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Randomized and directed self-checking bench for updown_counter_mod,
// checked against an arithmetic reference model of the counting rules.
module tb_updown_counter_mod;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic         sat_mode;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_zero;
  logic         wrap;
  logic         sat_hit;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int m_count;
  bit m_wrap;
  bit m_sat;

  updown_counter_mod #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .sat_mode (sat_mode),
    .count    (count),
    .at_max   (at_max),
    .at_zero  (at_zero),
    .wrap     (wrap),
    .sat_hit  (sat_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock: model computed from the inputs present before the edge.
  task automatic tick();
    int c, lim, nc;
    bit nw, ns;
    c   = m_count;
    lim = int'(limit);
    nc  = c;
    nw  = 1'b0;
    ns  = 1'b0;
    if (reset) begin
      nc = 0;
    end else if (load) begin
      nc = (int'(load_val) < lim) ? int'(load_val) : lim;
    end else if (en) begin
      if (up) begin
        if (sat_mode) begin
          nc = (c + 1 < lim) ? c + 1 : lim;
          ns = (c >= lim);
        end else if (c > lim) begin
          nc = 0;
          nw = 1'b1;
        end else begin
          nc = (c + 1) % (lim + 1);
          nw = (c == lim);
        end
      end else begin
        if (c > lim) begin
          nc = lim;
        end else if (sat_mode) begin
          nc = (c > 0) ? c - 1 : 0;
          ns = (c == 0);
        end else begin
          nc = (c + lim) % (lim + 1);
          nw = (c == 0);
        end
      end
    end
    @(posedge clk);
    #1;
    m_count = nc;
    m_wrap  = nw;
    m_sat   = ns;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_count = 0;
    m_wrap  = 1'b0;
    m_sat   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; sat_mode = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    limit = 4'd9;
    reset = 1'b1;
    #3;
    total_cnt++;
    if (count !== 4'd0 || wrap !== 1'b0 || sat_hit !== 1'b0 || at_zero !== 1'b1 || at_max !== 1'b0)
      $display("FAIL reset_state: got count=%0d wrap=%b sat=%b z=%b m=%b want 0 0 0 1 0",
               count, wrap, sat_hit, at_zero, at_max);
    else pass_cnt++;
    load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
    m_count = 0; m_wrap = 1'b0; m_sat = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0) $display("FAIL reset_ignores_load: got %0d want 0", count);
    else pass_cnt++;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_up_wrap();
    apply_reset();
    limit = 4'd9; sat_mode = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total_cnt++;
      if (count !== W'(i % 10) || wrap !== (i == 10) || at_max !== ((i % 10) == 9) || sat_hit !== 1'b0)
        $display("FAIL up_wrap step %0d: got count=%0d wrap=%b at_max=%b want count=%0d wrap=%b",
                 i, count, wrap, at_max, i % 10, (i == 10));
      else pass_cnt++;
    end
  endtask

  task automatic test_down_sat();
    idle_inputs();
    limit = 4'd15; load = 1'b1; load_val = 4'd2;
    tick();
    total_cnt++;
    if (count !== 4'd2) $display("FAIL down_sat_load: got %0d want 2", count);
    else pass_cnt++;
    load = 1'b0; sat_mode = 1'b1; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total_cnt++;
      if (count !== W'((i < 2) ? 2 - i : 0) || sat_hit !== (i >= 3) || wrap !== 1'b0)
        $display("FAIL down_sat step %0d: got count=%0d sat=%b wrap=%b", i, count, sat_hit, wrap);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_wrap_clamp();
    // count is 0 here, left by the saturating run
    limit = 4'd5; sat_mode = 1'b0; en = 1'b1; up = 1'b0; load = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd5 || wrap !== 1'b1 || sat_hit !== 1'b0)
      $display("FAIL down_wrap: got count=%0d wrap=%b want 5 1", count, wrap);
    else pass_cnt++;
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    total_cnt++;
    if (count !== 4'd5 || wrap !== 1'b0 || at_max !== 1'b1)
      $display("FAIL load_clamp: got count=%0d wrap=%b want 5 0", count, wrap);
    else pass_cnt++;
  endtask

  task automatic test_limit_drop();
    idle_inputs();
    limit = 4'd15; load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0; limit = 4'd7; en = 1'b1; up = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd7 || wrap !== 1'b0 || sat_hit !== 1'b0)
      $display("FAIL limit_drop: got count=%0d wrap=%b sat=%b want 7 0 0", count, wrap, sat_hit);
    else pass_cnt++;
    up = 1'b1; sat_mode = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || wrap !== 1'b1)
      $display("FAIL limit_drop_up: got count=%0d wrap=%b want 0 1", count, wrap);
    else pass_cnt++;
  endtask

  task automatic test_priority_async_reset();
    idle_inputs();
    limit = 4'd15; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd3;
    tick();
    total_cnt++;
    if (count !== 4'd3) $display("FAIL priority_load: got %0d want 3", count);
    else pass_cnt++;
    load = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (count !== 4'd6) $display("FAIL pre_reset_count: got %0d want 6", count);
    else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    total_cnt++;
    if (count !== 4'd0 || at_zero !== 1'b1) $display("FAIL async_reset: got %0d want 0", count);
    else pass_cnt++;
    m_count = 0; m_wrap = 1'b0; m_sat = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd1) $display("FAIL resume_after_reset: got %0d want 1", count);
    else pass_cnt++;
    // limit 0: wrap pulse, then reset mid-pulse must clear it at once
    limit = 4'd0; sat_mode = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || wrap !== 1'b1 || at_max !== 1'b1)
      $display("FAIL limit0_wrap: got count=%0d wrap=%b want 0 1", count, wrap);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (wrap !== 1'b0 || sat_hit !== 1'b0) $display("FAIL reset_mid_pulse: got wrap=%b want 0", wrap);
    else pass_cnt++;
    m_count = 0; m_wrap = 1'b0; m_sat = 1'b0;
    tick();
    reset = 1'b0;
    sat_mode = 1'b1;
    tick();
    total_cnt++;
    if (count !== 4'd0 || sat_hit !== 1'b1 || wrap !== 1'b0)
      $display("FAIL limit0_sat: got count=%0d sat=%b want 0 1", count, sat_hit);
    else pass_cnt++;
  endtask

  task automatic test_full_range();
    idle_inputs();
    apply_reset();
    limit = 4'd15; sat_mode = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      total_cnt++;
      if (count !== W'(i % 16) || wrap !== (i == 16))
        $display("FAIL full_range step %0d: got count=%0d wrap=%b want %0d %b",
                 i, count, wrap, i % 16, (i == 16));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int r;
    idle_inputs();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        #2;
        m_count = 0; m_wrap = 1'b0; m_sat = 1'b0;
        total_cnt++;
        if (count !== 4'd0 || wrap !== 1'b0 || sat_hit !== 1'b0)
          $display("FAIL rand_async_reset %0d: got count=%0d wrap=%b sat=%b", i, count, wrap, sat_hit);
        else pass_cnt++;
      end else begin
        reset = 1'b0;
      end
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      sat_mode = $urandom_range(0, 1);
      load_val = W'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0) limit = 4'd0;
      else if (r < 4) limit = 4'd15;
      else if (r < 6) limit = W'($urandom_range(0, 15));
      tick();
      reset = 1'b0;
      total_cnt++;
      if (int'(count) !== m_count || wrap !== m_wrap || sat_hit !== m_sat ||
          at_max !== (m_count == int'(limit)) || at_zero !== (m_count == 0) || (wrap && sat_hit))
        $display("FAIL random cyc %0d: got count=%0d wrap=%b sat=%b at_max=%b at_zero=%b want count=%0d wrap=%b sat=%b",
                 i, count, wrap, sat_hit, at_max, at_zero, m_count, m_wrap, m_sat);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    limit = 4'd9;
    m_count = 0; m_wrap = 1'b0; m_sat = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_down_wrap_clamp();
    test_limit_drop();
    test_priority_async_reset();
    test_full_range();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
